// File: rtl/dac_stim_scheduler_if.sv
// dac_stim_scheduler_if: stimulation request/acknowledge handshake
//   stim_req : scheduler -> stimulator, level request held until acknowledged
//   stim_ack : stimulator -> scheduler, acknowledge sampled every cycle
interface dac_stim_scheduler_if;
  logic stim_req;
  logic stim_ack;
  modport master (output stim_req, input stim_ack);
  modport slave (input stim_req, output stim_ack);
endinterface

// File: rtl/dac_stim_scheduler.sv
// dac_stim_scheduler: per-frame window discriminator FSM issuing stimulation requests with refractory lockout
//   dataclk/reset_n        : clock, async active-low reset
//   sample_tick            : one-cycle pulse per sample frame
//   fsm_mode               : discriminator enable, low forces DISABLED
//   DAC_en/in_window/thresh_out/edge_type : per-DAC condition inputs
//   DAC_stop_max           : last counter value of the track window
//   refractory             : lockout length in sample ticks
//   stim_hs                : req/ack handshake to the stimulator
//   DAC_fsm_counter        : state counter for the DAC window comparators
//   DAC_fsm_out            : one-hot state code
//   stim_count/stim_dropped: completed handshakes / advances lost to lockout
module dac_stim_scheduler #(
  parameter int NUM_DAC = 8,
  parameter int CW = 16
) (
  input  logic               dataclk,
  input  logic               reset_n,
  input  logic               sample_tick,
  input  logic               fsm_mode,
  input  logic [NUM_DAC-1:0] DAC_en,
  input  logic [NUM_DAC-1:0] DAC_in_window,
  input  logic [NUM_DAC-1:0] DAC_thresh_out,
  input  logic [NUM_DAC-1:0] DAC_edge_type,
  input  logic [CW-1:0]      DAC_stop_max,
  input  logic [CW-1:0]      refractory,
  dac_stim_scheduler_if.master stim_hs,
  output logic [CW-1:0]      DAC_fsm_counter,
  output logic [7:0]         DAC_fsm_out,
  output logic [15:0]        stim_count,
  output logic [7:0]         stim_dropped
);
  // State encoding equals the published output code, so the state register is the output
  typedef enum logic [7:0] {
    DISABLED = 8'h00,
    IDLE     = 8'h40,
    TRACK    = 8'h20,
    STIM     = 8'h10,
    REFRACT  = 8'h08
  } state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt_n, lock, lock_n;
  logic req, req_n, done, drop, advance;
  // Disabled or out-of-window channels are don't-cares; at least one channel must be enabled
  assign advance = &((DAC_thresh_out ^ DAC_edge_type) | ~DAC_in_window | ~DAC_en) & |DAC_en;
  assign DAC_fsm_out = state;
  assign stim_hs.stim_req = req;
  always_comb begin
    state_n = state;
    cnt_n = DAC_fsm_counter;
    lock_n = lock;
    req_n = req;
    done = 1'b0;
    drop = 1'b0;
    if (!fsm_mode) begin
      state_n = DISABLED;
      cnt_n = '0;
      lock_n = '0;
      req_n = 1'b0;
    end else begin
      case (state)
        DISABLED: begin
          state_n = IDLE;
          cnt_n = '0;
        end
        IDLE: if (sample_tick) begin
          state_n = advance ? TRACK : IDLE;
          cnt_n = advance ? CW'(1) : '0;
        end
        TRACK: if (sample_tick) begin
          if (!advance) begin
            state_n = IDLE;
            cnt_n = '0;
          end else if (DAC_fsm_counter >= DAC_stop_max) begin
            state_n = STIM;
            cnt_n = '0;
            req_n = 1'b1;
          end else begin
            cnt_n = DAC_fsm_counter + CW'(1);
          end
        end
        STIM: begin
          req_n = 1'b1;
          if (req && stim_hs.stim_ack) begin
            done = 1'b1;
            req_n = 1'b0;
            state_n = (refractory == '0) ? IDLE : REFRACT;
            lock_n = refractory;
          end
        end
        REFRACT: if (sample_tick) begin
          drop = advance;
          lock_n = (lock == '0) ? '0 : lock - CW'(1);
          state_n = (lock <= CW'(1)) ? IDLE : REFRACT;
        end
        default: state_n = DISABLED;
      endcase
    end
  end
  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= DISABLED;
      DAC_fsm_counter <= '0;
      lock <= '0;
      req <= 1'b0;
      stim_count <= '0;
      stim_dropped <= '0;
    end else begin
      state <= state_n;
      DAC_fsm_counter <= cnt_n;
      lock <= lock_n;
      req <= req_n;
      if (done) stim_count <= stim_count + 16'd1;
      if (drop && stim_dropped != 8'hFF) stim_dropped <= stim_dropped + 8'd1;
    end
  end
endmodule

// File: tb/tb_dac_stim_scheduler.sv
// tb_dac_stim_scheduler: table, directed and randomized checks of dac_stim_scheduler against a reference model
module tb_dac_stim_scheduler;
  localparam int CW = 16;
  localparam int N = 8;
  logic dataclk = 1'b0;
  logic reset_n = 1'b0;
  logic sample_tick = 1'b0;
  logic fsm_mode = 1'b0;
  logic [N-1:0] en = '0, win = '0, thr = '0, edg = '0;
  logic [CW-1:0] stop_max = '0, refr = '0;
  logic [CW-1:0] fsm_counter;
  logic [7:0] fsm_out;
  logic [15:0] scount;
  logic [7:0] sdrop;
  int total = 0;
  int bad = 0;
  int m_code, m_cnt, m_lock, m_req, m_sc, m_dr;

  dac_stim_scheduler_if sif();

  dac_stim_scheduler #(.NUM_DAC(N), .CW(CW)) dut (
    .dataclk(dataclk),
    .reset_n(reset_n),
    .sample_tick(sample_tick),
    .fsm_mode(fsm_mode),
    .DAC_en(en),
    .DAC_in_window(win),
    .DAC_thresh_out(thr),
    .DAC_edge_type(edg),
    .DAC_stop_max(stop_max),
    .refractory(refr),
    .stim_hs(sif),
    .DAC_fsm_counter(fsm_counter),
    .DAC_fsm_out(fsm_out),
    .stim_count(scount),
    .stim_dropped(sdrop)
  );

  always #5 dataclk = ~dataclk;

  typedef struct {
    bit tick;
    bit mode;
    bit adv_on;
    bit ack;
    int out;
    int cnt;
    int req;
    int sc;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance: some channel enabled, and every enabled in-window channel shows the required polarity
  function automatic bit model_adv();
    bit any = 0;
    bit ok = 1;
    for (int i = 0; i < N; i++) begin
      if (en[i]) any = 1;
      if (en[i] && win[i] && thr[i] == edg[i]) ok = 0;
    end
    return any && ok;
  endfunction

  task automatic model_reset();
    m_code = 0; m_cnt = 0; m_lock = 0; m_req = 0; m_sc = 0; m_dr = 0;
  endtask

  task automatic model_step();
    bit adv;
    adv = model_adv();
    if (!fsm_mode) begin
      m_code = 0; m_cnt = 0; m_req = 0; m_lock = 0;
    end else if (m_code == 0) begin
      m_code = 'h40; m_cnt = 0;
    end else if (m_code == 'h40) begin
      if (sample_tick) begin
        m_cnt = adv ? 1 : 0;
        m_code = adv ? 'h20 : 'h40;
      end
    end else if (m_code == 'h20) begin
      if (sample_tick && !adv) begin
        m_code = 'h40; m_cnt = 0;
      end else if (sample_tick && m_cnt >= int'(stop_max)) begin
        m_code = 'h10; m_cnt = 0; m_req = 1;
      end else if (sample_tick) m_cnt++;
    end else if (m_code == 'h10) begin
      if (sif.stim_ack) begin
        m_sc = (m_sc + 1) % 65536;
        m_req = 0;
        m_lock = int'(refr);
        m_code = (refr == 0) ? 'h40 : 'h08;
      end
    end else if (m_code == 'h08) begin
      if (sample_tick) begin
        if (adv && m_dr < 255) m_dr++;
        m_lock--;
        if (m_lock == 0) m_code = 'h40;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " out"}, 32'(fsm_out), 32'(m_code));
    chk({tag, " cnt"}, 32'(fsm_counter), 32'(m_cnt));
    chk({tag, " req"}, 32'(sif.stim_req), 32'(m_req));
    chk({tag, " scount"}, 32'(scount), 32'(m_sc));
    chk({tag, " dropped"}, 32'(sdrop), 32'(m_dr));
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge dataclk);
    @(negedge dataclk);
    check_model(tag);
  endtask

  task automatic set_adv(input bit a);
    en = 8'h01; win = 8'h01; edg = 8'h00; thr = a ? 8'h01 : 8'h00;
  endtask

  initial begin
    int sc0;
    sif.stim_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge dataclk);
    chk("reset out", 32'(fsm_out), 32'h00);
    chk("reset cnt", 32'(fsm_counter), 32'h0);
    chk("reset req", 32'(sif.stim_req), 32'h0);
    chk("reset scount", 32'(scount), 32'h0);
    chk("reset dropped", 32'(sdrop), 32'h0);
    reset_n = 1'b1;

    // Table: stop_max=3, refractory=0, ack tied high
    tbl[0] = '{0, 1, 1, 1, 'h40, 0, 0, 0};
    tbl[1] = '{1, 1, 1, 1, 'h20, 1, 0, 0};
    tbl[2] = '{1, 1, 1, 1, 'h20, 2, 0, 0};
    tbl[3] = '{1, 1, 1, 1, 'h20, 3, 0, 0};
    tbl[4] = '{1, 1, 1, 1, 'h10, 0, 1, 0};
    tbl[5] = '{1, 1, 1, 1, 'h40, 0, 0, 1};
    tbl[6] = '{1, 1, 1, 1, 'h20, 1, 0, 1};
    tbl[7] = '{0, 1, 0, 1, 'h20, 1, 0, 1};
    tbl[8] = '{1, 1, 0, 1, 'h40, 0, 0, 1};
    tbl[9] = '{1, 0, 1, 1, 'h00, 0, 0, 1};
    stop_max = 16'd3;
    refr = 16'd0;
    for (int i = 0; i < 10; i++) begin
      sample_tick = tbl[i].tick;
      fsm_mode = tbl[i].mode;
      sif.stim_ack = tbl[i].ack;
      set_adv(tbl[i].adv_on);
      cyc($sformatf("tbl%0d model", i));
      chk($sformatf("tbl%0d out", i), 32'(fsm_out), 32'(tbl[i].out));
      chk($sformatf("tbl%0d cnt", i), 32'(fsm_counter), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d req", i), 32'(sif.stim_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d scount", i), 32'(scount), 32'(tbl[i].sc));
    end

    // Advance lost at counter 2 with stop_max 5
    sample_tick = 1'b0; fsm_mode = 1'b1; sif.stim_ack = 1'b0; stop_max = 16'd5;
    cyc("drop idle");
    set_adv(1'b1); sample_tick = 1'b1;
    cyc("drop t1");
    cyc("drop t2");
    chk("drop cnt2", 32'(fsm_counter), 32'd2);
    set_adv(1'b0);
    cyc("drop t3");
    chk("drop back idle", 32'(fsm_out), 32'h40);
    chk("drop cnt0", 32'(fsm_counter), 32'd0);
    chk("drop no req", 32'(sif.stim_req), 32'd0);

    // Ack withheld in STIM, then disable aborts the request
    stop_max = 16'd0; set_adv(1'b1); sample_tick = 1'b1;
    cyc("abort t1");
    cyc("abort t2");
    chk("abort in stim", 32'(fsm_out), 32'h10);
    sc0 = m_sc;
    sample_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc("abort hold");
      chk("abort req held", 32'(sif.stim_req), 32'd1);
    end
    fsm_mode = 1'b0;
    cyc("abort off");
    chk("abort req low", 32'(sif.stim_req), 32'd0);
    chk("abort out", 32'(fsm_out), 32'h00);
    chk("abort scount", 32'(scount), 32'(sc0));

    // Refractory of 4 ticks with advance held
    fsm_mode = 1'b1; refr = 16'd4; stop_max = 16'd0;
    cyc("refr idle");
    sample_tick = 1'b1;
    cyc("refr t1");
    cyc("refr t2");
    chk("refr stim", 32'(fsm_out), 32'h10);
    sif.stim_ack = 1'b1;
    cyc("refr ack");
    chk("refr enter", 32'(fsm_out), 32'h08);
    chk("refr scount", 32'(scount), 32'(sc0 + 1));
    sif.stim_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc("refr tick");
      chk($sformatf("refr state %0d", i), 32'(fsm_out), (i < 4) ? 32'h08 : 32'h40);
      chk($sformatf("refr cnt %0d", i), 32'(fsm_counter), 32'd0);
    end
    chk("refr dropped", 32'(sdrop), 32'd4);

    // No enabled DAC never advances
    en = 8'h00; win = 8'hFF; edg = 8'h00; thr = 8'hFF; sample_tick = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc("noen");
      chk("noen idle", 32'(fsm_out), 32'h40);
    end

    // Async reset mid-TRACK
    set_adv(1'b1); stop_max = 16'd5;
    cyc("rst t1");
    cyc("rst t2");
    chk("rst in track", 32'(fsm_out), 32'h20);
    #2 reset_n = 1'b0;
    #1;
    chk("rst async out", 32'(fsm_out), 32'h00);
    chk("rst async cnt", 32'(fsm_counter), 32'd0);
    chk("rst async req", 32'(sif.stim_req), 32'd0);
    chk("rst async scount", 32'(scount), 32'd0);
    chk("rst async dropped", 32'(sdrop), 32'd0);
    model_reset();
    @(negedge dataclk);
    reset_n = 1'b1; fsm_mode = 1'b1; sample_tick = 1'b0;
    cyc("rst release");
    chk("rst idle", 32'(fsm_out), 32'h40);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if (i % 50 == 0) begin
        stop_max = CW'($urandom_range(0, 4));
        refr = CW'($urandom_range(0, 3));
      end
      sample_tick = ($urandom_range(0, 1) == 1);
      fsm_mode = ($urandom_range(0, 99) < 97);
      sif.stim_ack = ($urandom_range(0, 9) < 4);
      en = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      win = 8'($urandom);
      edg = 8'($urandom);
      thr = edg ^ (($urandom_range(0, 9) < 7) ? 8'hFF : 8'($urandom));
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dac_stim_scheduler.md
# dac_stim_scheduler

Sample-rate controller for the DAC window discriminator. It evaluates the per-DAC threshold and window flags once per sample frame and sequences a idle/track/stim state machine. It issues a stimulation request to the stimulator through a req/ack handshake, then enforces a programmable refractory lockout. It sits beside the DAC channel blocks on `dataclk`. It supplies them the state counter that drives their window comparators, and it consumes their threshold and in-window outputs.

## Interface
Parameters:
- `NUM_DAC`, 8: number of DAC channels evaluated.
- `CW`, 16: width of the state counter, `stop_max`, and the refractory counter.

Ports:
- `dataclk`, in, 1: sole clock, rising edge.
- `reset_n`, in, 1: asynchronous assert, active-low reset. Release is synchronous to `dataclk` upstream.
- `sample_tick`, in, 1: one-`dataclk` pulse per sample frame (channel-0 sample strobe).
- `fsm_mode`, in, 1: discriminator enable. Low forces the DISABLED state.
- `DAC_en`, in, NUM_DAC: per-DAC enable.
- `DAC_in_window`, in, NUM_DAC: per-DAC "state counter inside window" flag.
- `DAC_thresh_out`, in, NUM_DAC: per-DAC threshold comparator output.
- `DAC_edge_type`, in, NUM_DAC: per-DAC required polarity. The condition is met when thresh differs from edge_type.
- `DAC_stop_max`, in, CW: last counter value of the track window.
- `refractory`, in, CW: lockout length in sample ticks.
- `stim_ack`, in, 1: stimulator acknowledge.
- `DAC_fsm_counter`, out, CW: state counter fed to the DAC window comparators.
- `DAC_fsm_out`, out, 8: one-hot state code.
- `stim_req`, out, 1: stimulation request (level).
- `stim_count`, out, 16: completed handshakes, wrapping.
- `stim_dropped`, out, 8: advance events that arrived during REFRACT, saturating at 255.

## Operation
- `advance` is computed combinationally: `&((DAC_thresh_out ^ DAC_edge_type) | ~DAC_in_window | ~DAC_en) & |DAC_en`. With all DACs disabled, `advance` is never true.
- States and their `DAC_fsm_out` codes: DISABLED 0x00, IDLE 0x40, TRACK 0x20, STIM 0x10, REFRACT 0x08.
- Any state with `fsm_mode`=0 goes to DISABLED on the next edge. The counter is cleared to 0 and `stim_req` is dropped. An aborted STIM does not increment `stim_count`. This rule has priority over every other transition.
- DISABLED with `fsm_mode`=1 goes to IDLE.
- IDLE, on a tick with `advance`: go to TRACK, counter=1. A tick without `advance`: stay in IDLE, counter=0.
- TRACK, on a tick:
  - `advance` and counter >= `DAC_stop_max`: go to STIM, counter=0.
  - `advance` otherwise: counter+1.
  - No `advance`: go to IDLE, counter=0.
  - The comparison is `>=` so that lowering `stop_max` mid-track cannot strand the FSM.
- STIM: `stim_req`=1, independent of ticks. When `stim_req` and `stim_ack` are both high on an edge:
  - `stim_count` increments.
  - `stim_req` drops.
  - If `refractory`==0, go to IDLE; otherwise go to REFRACT with the lockout counter loaded with `refractory`.
- REFRACT: each tick decrements the lockout counter. The tick that takes it from 1 to 0 moves the state to IDLE. A tick with `advance` while in REFRACT increments `stim_dropped`, saturating at 255. `DAC_fsm_counter` holds 0 during REFRACT.
- `stim_count` and `stim_dropped` are cleared only by reset.

## Timing
- Reset (async, `reset_n`=0): state=DISABLED, `DAC_fsm_counter`=0, `DAC_fsm_out`=0x00, `stim_req`=0, `stim_count`=0, `stim_dropped`=0, lockout counter=0.
- All outputs are registered. The decision is made on the edge where `sample_tick`=1, and the result is visible on the following cycle (1-cycle latency).
- Inputs are sampled only on tick cycles, except `stim_ack` and `fsm_mode`, which are sampled every cycle.
- Entering STIM raises `stim_req` on the same edge as the state change. `stim_req` stays high until ack is seen. The minimum request is 1 cycle, when ack is already high on entry.
- A tick in the same cycle as the completing ack is not counted against the lockout. The countdown starts on the next tick.
- Tick and `fsm_mode` falling in the same cycle: DISABLED wins.
- Lockout length: exactly `refractory` ticks from the ack to the IDLE transition.

## Test plan
- Reset mid-TRACK: assert `reset_n`=0 asynchronously between edges → all outputs go to their reset values immediately. After release with `fsm_mode`=1, IDLE (0x40) appears 1 cycle later.
- `DAC_en`=0x01, `stop_max`=3, `refractory`=0, `advance` held true, ack tied high:
  - Counter reads 1, 2, 3 over successive ticks.
  - STIM at the 4th tick, `stim_req` high for 1 cycle, `stim_count`=1, then back to IDLE.
- `advance` drops at counter=2 with `stop_max`=5 → IDLE, counter 0, no request.
- ack withheld 10 cycles in STIM, then `fsm_mode`=0 → `stim_req` falls the next cycle, `stim_count` unchanged, `DAC_fsm_out`=0x00.
- `refractory`=4 with `advance` true for 4 ticks after ack → REFRACT (0x08) lasts exactly 4 ticks, `stim_dropped`=4, then IDLE.
- `DAC_en`=0x00 with all thresholds matching → never leaves IDLE over 100 ticks.
